regfile_wb_ctrl: RTL and testbench

//  Writeback controller and scoreboard for the integer register file.
//  - Round-robin shares the regfile's single write port (wr_en/wr_addr/wr_data) among NUM_SRC producers (ALU, LSU, CSR).
//  - Tracks a pending bit per architectural register.
//  - Flags RAW hazards on the read ports and stalls issue on WAW.
//  - Sits between the execute units and the regfile; the decode/issue stage uses it for hazard checks.

---
 rtl/riscv_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 49 ++++
 rtl/regfile_wb_ctrl.sv | 115 +++++++++++
 tb/tb_regfile_wb_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared integer-core definitions for the writeback controller and scoreboard.
// Contents:
//   XLEN        - register data width
//   REG_ADDR_W  - register address width
//   REGFILE_NUM - number of architectural registers (x0 hardwired zero)
//   wb_req_t    - one writeback request: destination register and result
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int REG_ADDR_W  = 5;
    localparam int REGFILE_NUM = 2 ** REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports:
//   clk  - clock, pointer updates on rising edge
//   rst  - asynchronous reset, active-low; forces pointer to 0 and grant to 0
//   req  - request vector, one bit per requester
//   gnt  - one-hot grant (or all zero), combinational from req and pointer
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;
    int               idx;

    // Scan requesters starting at the pointer; the first active one wins.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && rst && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = PTR_W'(idx);
                found    = 1'b1;
            end
        end
    end

    // Priority moves to the requester after the winner; holds when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == PTR_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller and register scoreboard.
// Shares the regfile write port among NUM_SRC producers in round-robin order,
// keeps one pending bit per architectural register, reports RAW hazards on the
// two read ports and holds issue on a WAW.
// Ports:
//   clk, rst               - clock and asynchronous active-low reset
//   req_vld/rdy/addr/data  - producer handshakes, slice i belongs to producer i
//   wr_en/wr_addr/wr_data  - registered regfile write port
//   issue_vld/rd/rdy       - decode destination-register reservation
//   rs1_*/rs2_*            - read-port hazard queries
//   flush                  - clears every pending bit
module regfile_wb_ctrl
    import riscv_pkg::*;
#(
    parameter int NUM_SRC = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req_vld,
    output logic [NUM_SRC-1:0]            req_rdy,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] req_addr,
    input  logic [NUM_SRC*XLEN-1:0]       req_data,
    output logic                          wr_en,
    output logic [REG_ADDR_W-1:0]         wr_addr,
    output logic [XLEN-1:0]               wr_data,
    input  logic                          issue_vld,
    input  logic [REG_ADDR_W-1:0]         issue_rd,
    output logic                          issue_rdy,
    input  logic                          rs1_en,
    input  logic [REG_ADDR_W-1:0]         rs1_addr,
    input  logic                          rs2_en,
    input  logic [REG_ADDR_W-1:0]         rs2_addr,
    output logic                          rs1_hazard,
    output logic                          rs2_hazard,
    input  logic                          flush
);

    wb_req_t                sel;
    logic                   accept;
    logic                   issue_fire;
    logic [REGFILE_NUM-1:0] pending;
    logic [REGFILE_NUM-1:0] pending_nxt;

    rr_arbiter #(.N(NUM_SRC)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_vld),
        .gnt (req_rdy)
    );

    // Select the granted producer's address and data.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (req_rdy[i]) begin
                sel.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                sel.data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    assign accept = |req_rdy;

    // Write port is one cycle behind the accept. Writes to x0 are swallowed,
    // and address/data only move on a real write so they hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept && (sel.addr != '0);
            if (accept && (sel.addr != '0)) begin
                wr_addr <= sel.addr;
                wr_data <= sel.data;
            end
        end
    end

    assign issue_rdy  = !pending[issue_rd] || (issue_rd == '0);
    assign issue_fire = issue_vld && issue_rdy && (issue_rd != '0);

    // Clear on accept, then set on issue, then flush overrides everything.
    // issue_rdy only looks at current state, so the same register is never
    // both cleared and set in one cycle.
    always_comb begin
        pending_nxt = pending;
        if (accept) begin
            pending_nxt[sel.addr] = 1'b0;
        end
        if (issue_fire) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        if (flush) begin
            pending_nxt = '0;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // The write-in-flight term covers the cycle where the regfile has not yet
    // captured the value, since its read is registered.
    assign rs1_hazard = rs1_en && (rs1_addr != '0) &&
                        (pending[rs1_addr] || (wr_en && (wr_addr == rs1_addr)));
    assign rs2_hazard = rs2_en && (rs2_addr != '0) &&
                        (pending[rs2_addr] || (wr_en && (wr_addr == rs2_addr)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by a
// randomized phase, all compared against a behavioural reference model.
module tb_regfile_wb_ctrl;
    import riscv_pkg::*;

    localparam int NS = 3;
    localparam int AW = REG_ADDR_W;
    localparam int XW = XLEN;

    logic             clk;
    logic             rst;
    logic [NS-1:0]    req_vld;
    logic [NS-1:0]    req_rdy;
    logic [NS*AW-1:0] req_addr;
    logic [NS*XW-1:0] req_data;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [XW-1:0]    wr_data;
    logic             issue_vld;
    logic [AW-1:0]    issue_rd;
    logic             issue_rdy;
    logic             rs1_en;
    logic [AW-1:0]    rs1_addr;
    logic             rs2_en;
    logic [AW-1:0]    rs2_addr;
    logic             rs1_hazard;
    logic             rs2_hazard;
    logic             flush;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit            m_pend [REGFILE_NUM];
    int            m_ptr;
    logic          m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [XW-1:0] m_wr_data;
    int            last_gnt;

    regfile_wb_ctrl #(.NUM_SRC(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_vld  (issue_vld),
        .issue_rd   (issue_rd),
        .issue_rdy  (issue_rdy),
        .rs1_en     (rs1_en),
        .rs1_addr   (rs1_addr),
        .rs2_en     (rs2_en),
        .rs2_addr   (rs2_addr),
        .rs1_hazard (rs1_hazard),
        .rs2_hazard (rs2_hazard),
        .flush      (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < REGFILE_NUM; r++) m_pend[r] = 1'b0;
        m_ptr     = 0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        last_gnt  = -1;
    endtask

    function automatic logic exp_hazard(input logic en, input logic [AW-1:0] a);
        return en && (a != 0) && (m_pend[a] || (m_wr_en && (m_wr_addr == a)));
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XW-1:0] d);
        req_vld[i]           = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*XW +: XW] = d;
    endtask

    // One clock: compare outputs at the falling edge, then advance the model
    // at the rising edge and return just after it.
    task automatic apply_stimulus();
        int            g;
        logic [NS-1:0] exp_rdy;
        logic          exp_irdy;
        logic [AW-1:0] a;
        @(negedge clk);
        g = -1;
        if (rst) begin
            for (int k = 0; k < NS; k++) begin
                if (g < 0 && req_vld[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_irdy = !m_pend[issue_rd] || (issue_rd == 0);
        check_output("req_rdy",    req_rdy,    exp_rdy);
        check_output("wr_en",      wr_en,      m_wr_en);
        check_output("wr_addr",    wr_addr,    m_wr_addr);
        check_output("wr_data",    wr_data,    m_wr_data);
        check_output("issue_rdy",  issue_rdy,  exp_irdy);
        check_output("rs1_hazard", rs1_hazard, exp_hazard(rs1_en, rs1_addr));
        check_output("rs2_hazard", rs2_hazard, exp_hazard(rs2_en, rs2_addr));
        @(posedge clk);
        if (rst) begin
            m_wr_en = 1'b0;
            if (g >= 0) begin
                a = req_addr[g*AW +: AW];
                m_pend[a] = 1'b0;
                if (a != 0) begin
                    m_wr_en   = 1'b1;
                    m_wr_addr = a;
                    m_wr_data = req_data[g*XW +: XW];
                end
                m_ptr = (g + 1) % NS;
            end
            if (issue_vld && exp_irdy && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            if (flush) for (int r = 0; r < REGFILE_NUM; r++) m_pend[r] = 1'b0;
            m_pend[0] = 1'b0;
        end
        last_gnt = g;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req_vld = '1; req_addr = '0; req_data = '0;
        issue_vld = 1'b0; issue_rd = '0;
        rs1_en = 1'b1; rs1_addr = 5'd5; rs2_en = 1'b1; rs2_addr = 5'd9;
        flush = 1'b0;
        model_reset();
        for (int i = 0; i < NS; i++) set_req(i, AW'(i + 1), XW'($urandom));

        $display("[TB] reset with all requesters valid");
        #2;
        apply_stimulus();
        apply_stimulus();
        rst = 1'b1;

        $display("[TB] round robin with all requesters valid");
        for (int k = 0; k < 6; k++) begin
            #3;
            check_output("rr_order", req_rdy, 3'b001 << (k % 3));
            apply_stimulus();
            set_req(last_gnt, AW'($urandom_range(1, 31)), XW'($urandom));
        end
        req_vld = '0;

        $display("[TB] write to x0");
        set_req(1, '0, 32'hDEADBEEF);
        #3;
        check_output("x0_rdy", req_rdy, 3'b010);
        apply_stimulus();
        req_vld = '0;
        #3;
        check_output("x0_wr_en", wr_en, 1'b0);
        apply_stimulus();

        $display("[TB] scoreboard on x5");
        rs1_addr = 5'd5; rs2_en = 1'b0;
        issue_vld = 1'b1; issue_rd = 5'd5;
        apply_stimulus();
        issue_vld = 1'b0;
        #3;
        check_output("x5_issue_rdy", issue_rdy, 1'b0);
        check_output("x5_haz_pend", rs1_hazard, 1'b1);
        apply_stimulus();
        set_req(2, 5'd5, 32'h1234);
        apply_stimulus();
        req_vld = '0;
        #3;
        check_output("x5_haz_wb", rs1_hazard, 1'b1);
        apply_stimulus();
        #3;
        check_output("x5_haz_clr", rs1_hazard, 1'b0);
        apply_stimulus();

        $display("[TB] clear and set in one cycle");
        issue_vld = 1'b1; issue_rd = 5'd9;
        apply_stimulus();
        issue_rd = 5'd7;
        set_req(0, 5'd9, XW'($urandom));
        apply_stimulus();
        req_vld = '0;
        issue_rd = 5'd9; rs1_addr = 5'd7;
        #3;
        check_output("x9_reissue_rdy", issue_rdy, 1'b1);
        check_output("x7_pending", rs1_hazard, 1'b1);
        apply_stimulus();
        issue_vld = 1'b0;

        $display("[TB] flush with a write in flight");
        foreach (issue_rd[b]) issue_rd[b] = 1'b0;
        issue_vld = 1'b1;
        issue_rd = 5'd3; apply_stimulus();
        issue_rd = 5'd4; apply_stimulus();
        issue_rd = 5'd6; apply_stimulus();
        issue_vld = 1'b0;
        set_req(0, 5'd3, 32'hCAFE0003);
        flush = 1'b1;
        apply_stimulus();
        flush = 1'b0; req_vld = '0;
        rs1_addr = 5'd4; rs2_en = 1'b1; rs2_addr = 5'd6;
        #3;
        check_output("flush_wr_en", wr_en, 1'b1);
        check_output("flush_wr_addr", wr_addr, 5'd3);
        check_output("flush_haz4", rs1_hazard, 1'b0);
        check_output("flush_haz6", rs2_hazard, 1'b0);
        apply_stimulus();

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1'b0;
                req_vld = '0;
                model_reset();
                apply_stimulus();
                rst = 1'b1;
            end
            for (int i = 0; i < NS; i++) begin
                if (i == last_gnt) begin
                    req_vld[i] = 1'($urandom_range(0, 1));
                    if (req_vld[i]) set_req(i, AW'($urandom_range(0, 7)), XW'($urandom));
                end else if (!req_vld[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, AW'($urandom_range(0, 7)), XW'($urandom));
                end
            end
            issue_vld = 1'($urandom_range(0, 1));
            issue_rd  = AW'($urandom_range(0, 7));
            rs1_en    = 1'($urandom_range(0, 1));
            rs1_addr  = AW'($urandom_range(0, 7));
            rs2_en    = 1'($urandom_range(0, 1));
            rs2_addr  = AW'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 19) == 0);
            apply_stimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
